// File: rtl/hack_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// hack_mem_arbiter_if
// Bundles the signals between the HACK RAM arbiter and its environment:
// the two requesters (instruction fetch on port A, data on port B) and the
// single-port RAM.
//
// Signals:
//   a_req/a_addr            port A read request and address
//   a_gnt/a_rvalid/a_rdata  port A grant, read-valid, read data
//   b_req/b_we/b_addr/b_wdata port B request, write enable, address, data
//   b_gnt/b_rvalid/b_rdata  port B grant, read-valid, read data
//   mem_load/mem_address/mem_data  drive to the RAM
//   mem_out                 RAM registered read data (1-cycle latency)
//   busy                    zero-fill sequence in progress
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus RAM)
// ---------------------------------------------------------------------------
interface hack_mem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13
);
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              mem_load;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_out;

    logic              busy;

    modport slave (
        input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_out,
        output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
        output mem_load, mem_address, mem_data, busy
    );

    modport master (
        output a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_out,
        input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
        input  mem_load, mem_address, mem_data, busy
    );
endinterface

// File: rtl/hack_mem_arbiter.sv
// ---------------------------------------------------------------------------
// hack_mem_arbiter
// Shares the single-port HACK RAM between a read-only fetch port (A) and a
// read/write data port (B). One RAM access per cycle, round-robin on
// contention, grants are combinational in the request cycle and read data
// follows one cycle later with the RAM's registered-read latency. After reset
// an optional zero-fill pass writes CLR_LEN words starting at CLR_BASE
// (wrapping at 2^ADDR_W) before any requester is granted.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    hack_mem_arbiter_if.slave (requesters, RAM drive, busy)
// ---------------------------------------------------------------------------
module hack_mem_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 13,
    parameter int CLR_BASE = 0,
    parameter int CLR_LEN  = 0
) (
    input  logic               clk,
    input  logic               reset,
    hack_mem_arbiter_if.slave  bus
);
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t            RST_STATE = (CLR_LEN > 0) ? ST_INIT : ST_RUN;
    localparam logic [ADDR_W-1:0] CLR_ADDR0 = ADDR_W'(CLR_BASE);
    localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'((CLR_LEN > 0) ? CLR_LEN - 1 : 0);
    localparam logic              GNT_A     = 1'b0;
    localparam logic              GNT_B     = 1'b1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_last_gnt;
    logic              w_last_gnt_nxt;
    logic              r_a_pend;
    logic              r_b_pend;

    logic              w_a_gnt;
    logic              w_b_gnt;
    logic              w_mem_load;
    logic [ADDR_W-1:0] w_mem_address;
    logic [DATA_W-1:0] w_mem_data;
    logic              w_busy;

    // Next-state, grant selection and RAM drive.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_last_gnt_nxt = r_last_gnt;
        w_a_gnt        = 1'b0;
        w_b_gnt        = 1'b0;
        w_mem_load     = 1'b0;
        w_mem_address  = '0;
        w_mem_data     = '0;
        w_busy         = 1'b0;

        case (r_state)
            ST_INIT: begin
                // One zero write per cycle; the address wraps naturally in ADDR_W bits.
                w_busy        = 1'b1;
                w_mem_load    = 1'b1;
                w_mem_address = CLR_ADDR0 + r_cnt;
                w_mem_data    = '0;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                // A wins if alone, or on a tie when B was granted last.
                if (bus.a_req && (!bus.b_req || (r_last_gnt == GNT_B))) begin
                    w_a_gnt        = 1'b1;
                    w_last_gnt_nxt = GNT_A;
                    w_mem_address  = bus.a_addr;
                end else if (bus.b_req) begin
                    w_b_gnt        = 1'b1;
                    w_last_gnt_nxt = GNT_B;
                    w_mem_load     = bus.b_we;
                    w_mem_address  = bus.b_addr;
                    w_mem_data     = bus.b_wdata;
                end else begin
                    w_last_gnt_nxt = r_last_gnt;
                end
            end
            default: begin
                w_state_nxt = RST_STATE;
            end
        endcase

        // Reset must not leak an access to the RAM or a grant to a requester.
        if (reset) begin
            w_a_gnt    = 1'b0;
            w_b_gnt    = 1'b0;
            w_mem_load = 1'b0;
            w_busy     = (RST_STATE == ST_INIT);
        end else begin
            w_busy     = w_busy;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Init counter, round-robin history and read-pending flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_last_gnt <= GNT_B;
            r_a_pend   <= 1'b0;
            r_b_pend   <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            r_a_pend   <= w_a_gnt;
            r_b_pend   <= w_b_gnt & ~bus.b_we;
        end
    end

    assign bus.a_gnt       = w_a_gnt;
    assign bus.b_gnt       = w_b_gnt;
    assign bus.mem_load    = w_mem_load;
    assign bus.mem_address = w_mem_address;
    assign bus.mem_data    = w_mem_data;
    assign bus.busy        = w_busy;

    // A read granted just before reset must not surface while reset is held.
    assign bus.a_rvalid = r_a_pend & ~reset;
    assign bus.b_rvalid = r_b_pend & ~reset;
    assign bus.a_rdata  = bus.mem_out;
    assign bus.b_rdata  = bus.mem_out;
endmodule

// File: tb/tb_hack_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hack_mem_arbiter
// Directed bench for hack_mem_arbiter. Three instances cover the three
// configurations of interest: zero-fill with wrap (base 8190, len 4), no
// zero-fill, and zero-fill at base 100 len 6 for the reset-mid-init case.
// Each instance has its own behavioural RAM with a registered read port.
// Inputs change on the falling edge and outputs are checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_hack_mem_arbiter;
    logic clk = 1'b0;
    logic rst_w;
    logic rst_r;
    logic rst_i;
    logic fill;
    int   n_cmp = 0;
    int   n_err = 0;

    hack_mem_arbiter_if #(.DATA_W(16), .ADDR_W(13)) if_w ();
    hack_mem_arbiter_if #(.DATA_W(16), .ADDR_W(13)) if_r ();
    hack_mem_arbiter_if #(.DATA_W(16), .ADDR_W(13)) if_i ();

    hack_mem_arbiter #(.DATA_W(16), .ADDR_W(13), .CLR_BASE(8190), .CLR_LEN(4))
        u_wrap (.clk(clk), .reset(rst_w), .bus(if_w));
    hack_mem_arbiter #(.DATA_W(16), .ADDR_W(13), .CLR_BASE(0), .CLR_LEN(0))
        u_run  (.clk(clk), .reset(rst_r), .bus(if_r));
    hack_mem_arbiter #(.DATA_W(16), .ADDR_W(13), .CLR_BASE(100), .CLR_LEN(6))
        u_init (.clk(clk), .reset(rst_i), .bus(if_i));

    logic [15:0] ram_w [8192];
    logic [15:0] ram_r [8192];
    logic [15:0] ram_i [8192];

    always #5 clk = ~clk;

    // RAM models: preset pattern while fill is high, else write/registered read.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 8192; i++) begin
                ram_w[i] <= 16'hDEAD;
                ram_r[i] <= 16'hDEAD;
                ram_i[i] <= 16'hDEAD;
            end
            ram_r[1] <= 16'h1111;
            ram_r[2] <= 16'h2222;
        end else begin
            if (if_w.mem_load) ram_w[if_w.mem_address] <= if_w.mem_data;
            if (if_r.mem_load) ram_r[if_r.mem_address] <= if_r.mem_data;
            if (if_i.mem_load) ram_i[if_i.mem_address] <= if_i.mem_data;
            if_w.mem_out <= ram_w[if_w.mem_address];
            if_r.mem_out <= ram_r[if_r.mem_address];
            if_i.mem_out <= ram_i[if_i.mem_address];
        end
    end

    task automatic test_reset();
        // Requests during reset must not be granted.
        if_w.a_req = 1'b1; if_w.b_req = 1'b1;
        if_r.a_req = 1'b1; if_r.b_req = 1'b1; if_r.b_we = 1'b1;
        if_i.a_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({if_w.a_gnt, if_w.b_gnt, if_w.mem_load, if_w.busy, if_w.a_rvalid, if_w.b_rvalid} !== 6'b000100) begin
            n_err++;
            $display("FAIL reset_wrap: got %b expected %b", {if_w.a_gnt, if_w.b_gnt, if_w.mem_load, if_w.busy, if_w.a_rvalid, if_w.b_rvalid}, 6'b000100);
        end
        n_cmp++;
        if ({if_r.a_gnt, if_r.b_gnt, if_r.mem_load, if_r.busy, if_r.a_rvalid, if_r.b_rvalid} !== 6'b000000) begin
            n_err++;
            $display("FAIL reset_run: got %b expected %b", {if_r.a_gnt, if_r.b_gnt, if_r.mem_load, if_r.busy, if_r.a_rvalid, if_r.b_rvalid}, 6'b000000);
        end
        n_cmp++;
        if ({if_i.a_gnt, if_i.b_gnt, if_i.mem_load, if_i.busy, if_i.a_rvalid, if_i.b_rvalid} !== 6'b000100) begin
            n_err++;
            $display("FAIL reset_init: got %b expected %b", {if_i.a_gnt, if_i.b_gnt, if_i.mem_load, if_i.busy, if_i.a_rvalid, if_i.b_rvalid}, 6'b000100);
        end
        if_r.a_req = 1'b0; if_r.b_req = 1'b0; if_r.b_we = 1'b0;
        if_i.a_req = 1'b0;
    endtask

    task automatic test_init_wrap();
        logic [12:0] exp_addr [4];
        exp_addr = '{13'd8190, 13'd8191, 13'd0, 13'd1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rst_w = 1'b0;
                if_w.a_req = 1'b1; if_w.a_addr = 13'd5;
                if_w.b_req = 1'b1; if_w.b_we = 1'b0; if_w.b_addr = 13'd6;
            end
            #1;
            n_cmp++;
            if ({if_w.mem_load, if_w.busy, if_w.a_gnt, if_w.b_gnt, if_w.mem_address, if_w.mem_data} !== {4'b1100, exp_addr[i], 16'h0000}) begin
                n_err++;
                $display("FAIL init_wrap[%0d]: got ld/busy/ag/bg=%b addr=%0d data=%h expected 1100 addr=%0d data=0000",
                         i, {if_w.mem_load, if_w.busy, if_w.a_gnt, if_w.b_gnt}, if_w.mem_address, if_w.mem_data, exp_addr[i]);
            end
        end
        // First grant possible in cycle CLR_LEN: A reads 8191.
        @(negedge clk);
        if_w.b_req = 1'b0; if_w.a_addr = 13'd8191;
        #1;
        n_cmp++;
        if ({if_w.mem_load, if_w.busy, if_w.a_gnt, if_w.b_gnt, if_w.mem_address} !== {4'b0010, 13'd8191}) begin
            n_err++;
            $display("FAIL wrap_first_gnt: got %b addr=%0d expected 0010 addr=8191", {if_w.mem_load, if_w.busy, if_w.a_gnt, if_w.b_gnt}, if_w.mem_address);
        end
        @(negedge clk);
        if_w.a_addr = 13'd1;
        #1;
        n_cmp++;
        if ({if_w.a_gnt, if_w.a_rvalid, if_w.a_rdata, if_w.mem_address} !== {2'b11, 16'h0000, 13'd1}) begin
            n_err++;
            $display("FAIL wrap_rd8191: got gnt/rv=%b rdata=%h addr=%0d expected 11 0000 1", {if_w.a_gnt, if_w.a_rvalid}, if_w.a_rdata, if_w.mem_address);
        end
        @(negedge clk);
        if_w.a_req = 1'b0;
        #1;
        n_cmp++;
        if ({if_w.a_gnt, if_w.a_rvalid, if_w.a_rdata} !== {2'b01, 16'h0000}) begin
            n_err++;
            $display("FAIL wrap_rd1: got gnt/rv=%b rdata=%h expected 01 0000", {if_w.a_gnt, if_w.a_rvalid}, if_w.a_rdata);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({if_w.a_rvalid, ram_w[13'd2], ram_w[13'd8189]} !== {1'b0, 16'hDEAD, 16'hDEAD}) begin
            n_err++;
            $display("FAIL wrap_window: got rv=%b ram[2]=%h ram[8189]=%h expected 0 dead dead", if_w.a_rvalid, ram_w[13'd2], ram_w[13'd8189]);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        rst_r = 1'b0;
        if_r.a_req = 1'b0;
        if_r.b_req = 1'b1; if_r.b_we = 1'b1; if_r.b_addr = 13'd50; if_r.b_wdata = 16'h1234;
        #1;
        n_cmp++;
        if ({if_r.b_gnt, if_r.a_gnt, if_r.mem_load, if_r.b_rvalid, if_r.mem_address, if_r.mem_data} !== {4'b1010, 13'd50, 16'h1234}) begin
            n_err++;
            $display("FAIL wr_b: got bg/ag/ld/brv=%b addr=%0d data=%h expected 1010 50 1234",
                     {if_r.b_gnt, if_r.a_gnt, if_r.mem_load, if_r.b_rvalid}, if_r.mem_address, if_r.mem_data);
        end
        @(negedge clk);
        if_r.b_req = 1'b0; if_r.b_we = 1'b0;
        if_r.a_req = 1'b1; if_r.a_addr = 13'd50;
        #1;
        n_cmp++;
        if ({if_r.a_gnt, if_r.b_gnt, if_r.mem_load, if_r.b_rvalid, if_r.mem_address} !== {4'b1000, 13'd50}) begin
            n_err++;
            $display("FAIL rd_a_gnt: got ag/bg/ld/brv=%b addr=%0d expected 1000 50", {if_r.a_gnt, if_r.b_gnt, if_r.mem_load, if_r.b_rvalid}, if_r.mem_address);
        end
        @(negedge clk);
        if_r.a_req = 1'b0;
        #1;
        n_cmp++;
        if ({if_r.a_rvalid, if_r.b_rvalid, if_r.a_gnt, if_r.a_rdata} !== {3'b100, 16'h1234}) begin
            n_err++;
            $display("FAIL rd_a_data: got arv/brv/ag=%b rdata=%h expected 100 1234", {if_r.a_rvalid, if_r.b_rvalid, if_r.a_gnt}, if_r.a_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic       exp_ag, exp_bg, exp_av, exp_bv;
        logic [15:0] exp_rd;
        @(negedge clk);
        rst_r = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                rst_r = 1'b0;
                if_r.a_req = 1'b1; if_r.a_addr = 13'd1;
                if_r.b_req = 1'b1; if_r.b_we = 1'b0; if_r.b_addr = 13'd2;
            end else if (k == 4) begin
                if_r.a_req = 1'b0; if_r.b_req = 1'b0;
            end else begin
                if_r.a_req = 1'b1;
            end
            #1;
            exp_ag = (k < 4) && ((k % 2) == 0);
            exp_bg = (k < 4) && ((k % 2) == 1);
            exp_av = (k > 0) && (((k - 1) % 2) == 0);
            exp_bv = (k > 0) && (((k - 1) % 2) == 1);
            n_cmp++;
            if ({if_r.a_gnt, if_r.b_gnt, if_r.a_rvalid, if_r.b_rvalid} !== {exp_ag, exp_bg, exp_av, exp_bv}) begin
                n_err++;
                $display("FAIL rr_seq[%0d]: got ag/bg/arv/brv=%b expected %b", k,
                         {if_r.a_gnt, if_r.b_gnt, if_r.a_rvalid, if_r.b_rvalid}, {exp_ag, exp_bg, exp_av, exp_bv});
            end
            if (k > 0) begin
                exp_rd = exp_av ? 16'h1111 : 16'h2222;
                n_cmp++;
                if ((exp_av ? if_r.a_rdata : if_r.b_rdata) !== exp_rd) begin
                    n_err++;
                    $display("FAIL rr_data[%0d]: got %h expected %h", k, (exp_av ? if_r.a_rdata : if_r.b_rdata), exp_rd);
                end
            end
        end
    endtask

    task automatic test_b_write_read();
        @(negedge clk);
        if_r.b_req = 1'b1; if_r.b_we = 1'b1; if_r.b_addr = 13'd3; if_r.b_wdata = 16'h00FF;
        #1;
        n_cmp++;
        if ({if_r.b_gnt, if_r.mem_load, if_r.mem_address, if_r.mem_data} !== {2'b11, 13'd3, 16'h00FF}) begin
            n_err++;
            $display("FAIL bwr_gnt: got bg/ld=%b addr=%0d data=%h expected 11 3 00ff", {if_r.b_gnt, if_r.mem_load}, if_r.mem_address, if_r.mem_data);
        end
        @(negedge clk);
        if_r.b_we = 1'b0;
        #1;
        n_cmp++;
        if ({if_r.b_gnt, if_r.mem_load, if_r.b_rvalid, if_r.mem_address} !== {3'b100, 13'd3}) begin
            n_err++;
            $display("FAIL brd_gnt: got bg/ld/brv=%b addr=%0d expected 100 3", {if_r.b_gnt, if_r.mem_load, if_r.b_rvalid}, if_r.mem_address);
        end
        @(negedge clk);
        if_r.b_req = 1'b0;
        #1;
        n_cmp++;
        if ({if_r.b_rvalid, if_r.b_gnt, if_r.b_rdata} !== {2'b10, 16'h00FF}) begin
            n_err++;
            $display("FAIL brd_data: got brv/bg=%b rdata=%h expected 10 00ff", {if_r.b_rvalid, if_r.b_gnt}, if_r.b_rdata);
        end
    endtask

    task automatic test_reset_pending();
        @(negedge clk);
        if_r.a_req = 1'b1; if_r.a_addr = 13'd7;
        #1;
        n_cmp++;
        if (if_r.a_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rp_gnt: got %b expected 1", if_r.a_gnt);
        end
        @(negedge clk);
        if_r.a_req = 1'b0; rst_r = 1'b1;
        #1;
        n_cmp++;
        if ({if_r.a_rvalid, if_r.b_rvalid, if_r.mem_load} !== 3'b000) begin
            n_err++;
            $display("FAIL rp_in_reset: got arv/brv/ld=%b expected 000", {if_r.a_rvalid, if_r.b_rvalid, if_r.mem_load});
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rst_r = 1'b0;
            #1;
            n_cmp++;
            if ({if_r.a_rvalid, if_r.b_rvalid} !== 2'b00) begin
                n_err++;
                $display("FAIL rp_after[%0d]: got arv/brv=%b expected 00", k, {if_r.a_rvalid, if_r.b_rvalid});
            end
        end
    endtask

    task automatic test_reset_mid_init();
        logic [12:0] exp_a;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rst_i = 1'b0;
                if_i.a_req = 1'b1; if_i.a_addr = 13'd9;
            end
            #1;
            exp_a = 13'd100 + 13'(i);
            n_cmp++;
            if ({if_i.mem_load, if_i.busy, if_i.a_gnt, if_i.b_gnt, if_i.mem_address} !== {4'b1100, exp_a}) begin
                n_err++;
                $display("FAIL mid_pre[%0d]: got %b addr=%0d expected 1100 addr=%0d", i, {if_i.mem_load, if_i.busy, if_i.a_gnt, if_i.b_gnt}, if_i.mem_address, exp_a);
            end
        end
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({if_i.mem_load, if_i.busy, if_i.a_gnt, if_i.b_gnt} !== 4'b0100) begin
            n_err++;
            $display("FAIL mid_reset: got %b expected 0100", {if_i.mem_load, if_i.busy, if_i.a_gnt, if_i.b_gnt});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst_i = 1'b0;
            #1;
            exp_a = 13'd100 + 13'(i);
            n_cmp++;
            if ({if_i.mem_load, if_i.busy, if_i.a_gnt, if_i.b_gnt, if_i.mem_address} !== {4'b1100, exp_a}) begin
                n_err++;
                $display("FAIL mid_restart[%0d]: got %b addr=%0d expected 1100 addr=%0d", i, {if_i.mem_load, if_i.busy, if_i.a_gnt, if_i.b_gnt}, if_i.mem_address, exp_a);
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({if_i.mem_load, if_i.busy, if_i.a_gnt, if_i.b_gnt, if_i.mem_address} !== {4'b0010, 13'd9}) begin
            n_err++;
            $display("FAIL mid_first_gnt: got %b addr=%0d expected 0010 addr=9", {if_i.mem_load, if_i.busy, if_i.a_gnt, if_i.b_gnt}, if_i.mem_address);
        end
        n_cmp++;
        if ({ram_i[100], ram_i[105], ram_i[106]} !== {16'h0000, 16'h0000, 16'hDEAD}) begin
            n_err++;
            $display("FAIL mid_window: got %h %h %h expected 0000 0000 dead", ram_i[100], ram_i[105], ram_i[106]);
        end
        @(negedge clk);
        if_i.a_req = 1'b0;
    endtask

    initial begin
        fill = 1'b1;
        rst_w = 1'b1; rst_r = 1'b1; rst_i = 1'b1;
        if_w.a_req = 1'b0; if_w.a_addr = '0; if_w.b_req = 1'b0; if_w.b_we = 1'b0; if_w.b_addr = '0; if_w.b_wdata = '0;
        if_r.a_req = 1'b0; if_r.a_addr = '0; if_r.b_req = 1'b0; if_r.b_we = 1'b0; if_r.b_addr = '0; if_r.b_wdata = '0;
        if_i.a_req = 1'b0; if_i.a_addr = '0; if_i.b_req = 1'b0; if_i.b_we = 1'b0; if_i.b_addr = '0; if_i.b_wdata = '0;
        @(negedge clk);
        fill = 1'b0;

        test_reset();
        test_init_wrap();
        test_write_read();
        test_round_robin();
        test_b_write_read();
        test_reset_pending();
        test_reset_mid_init();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hack_mem_arbiter.md
# hack_mem_arbiter

Shares the single-port 16-bit × 8192-word HACK RAM between two requesters: port A, a read-only instruction-fetch port, and port B, a read/write data port. The block issues at most one RAM access per cycle and arbitrates round-robin on contention. It returns read data with the RAM's one-cycle registered-read latency. After reset it can run an optional zero-fill sequence over a configurable address window before granting any requester. It sits between the CPU fetch/data interfaces and the RAM.

## Interface
- `DATA_W`, default 16: data word width.
- `ADDR_W`, default 13: address width (8192 words).
- `CLR_BASE`, default 0: first address of the zero-fill window.
- `CLR_LEN`, default 0: number of words to zero-fill (0..8192); 0 disables the init sequence.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `a_req`  in  1  port A read request
- `a_addr`  in  ADDR_W  port A read address
- `a_gnt`  out  1  port A access issued this cycle
- `a_rvalid`  out  1  `a_rdata` valid (one cycle after a granted A read)
- `a_rdata`  out  DATA_W  port A read data
- `b_req`  in  1  port B request
- `b_we`  in  1  port B write (1) or read (0)
- `b_addr`  in  ADDR_W  port B address
- `b_wdata`  in  DATA_W  port B write data
- `b_gnt`  out  1  port B access issued this cycle
- `b_rvalid`  out  1  `b_rdata` valid (one cycle after a granted B read)
- `b_rdata`  out  DATA_W  port B read data
- `mem_load`  out  1  to RAM `load`
- `mem_address`  out  ADDR_W  to RAM `address`
- `mem_data`  out  DATA_W  to RAM `data`
- `mem_out`  in  DATA_W  from RAM `out` (registered, 1-cycle latency)
- `busy`  out  1  init sequence in progress

## Operation
- **States.** There are two states, INIT and RUN.
  - Reset enters INIT when `CLR_LEN` > 0, otherwise RUN.
- **INIT.**
  - One zero write per cycle: `mem_load`=1, `mem_address`=(CLR_BASE+cnt) mod 2^ADDR_W, `mem_data`=0.
  - `cnt` increments each cycle. After write number `CLR_LEN`, the block moves to RUN.
  - `a_gnt`=`b_gnt`=0 and `busy`=1 throughout INIT. Requests are ignored, not queued.
- **RUN, access selection.**
  - Only one port requesting: that port is granted.
  - Both requesting: the port not granted most recently is granted.
  - `last_gnt` resets to B, so A wins the first tie.
  - `last_gnt` updates on every grant.
- **RUN, RAM drive.**
  - `mem_*` are driven combinationally from the granted port.
  - A grant always gives `mem_load`=0.
  - B grant gives `mem_load`=`b_we` and `mem_data`=`b_wdata`.
  - With no grant, `mem_load`=0; `mem_address`/`mem_data` are don't-care.
- **Request handshake.**
  - `gnt` is combinational, in the same cycle as the request.
  - The requester holds `req`/`addr`/`we`/`wdata` stable until it sees `gnt`.
  - It may change them or drop `req` in the cycle after `gnt`.
  - A held `req` with `gnt` gets one access per cycle.
- **Reads.**
  - A granted read sets that port's pending flag. The next cycle, the port's `rvalid`=1 for exactly one cycle.
  - `a_rdata` and `b_rdata` both pass `mem_out` through; they are meaningful only while `rvalid` is high.
- **Writes.**
  - A B write completes when `b_gnt` is asserted; it produces no `b_rvalid`.
  - A read of the same address in a later cycle returns the new data.

## Timing
- **While `reset`=1:**
  - `a_gnt`, `b_gnt` and `mem_load` are forced to 0.
  - The registered outputs take their reset values on the clock edge: `a_rvalid`=0, `b_rvalid`=0, `cnt`=0, `last_gnt`=B.
  - `busy`=1 if `CLR_LEN`>0, else 0.
- **Init timing.** The first init write happens in the first cycle after reset deasserts. `busy` is high for exactly `CLR_LEN` cycles after reset deasserts; the first grant is possible in cycle `CLR_LEN`.
- **Wrap-around.** The init address wraps modulo 8192; `CLR_BASE`+`CLR_LEN` > 8192 is legal.
- **Reset mid-init.** Init restarts from `CLR_BASE`.
- **Reset with a read pending.** The `rvalid` is suppressed; the pending flags are cleared.
- **Read latency.** Exactly 1 cycle from `gnt` to `rvalid`.
- **Throughput.** 1 access per cycle total. Under continuous contention, grants alternate A, B, A, B.
- **Pipelined reads.** `rvalid` may be high in the same cycle as a new `gnt` of the same port, so back-to-back reads pipeline.

## Test plan
- **Init with wrap.** Set `CLR_LEN`=4, `CLR_BASE`=8190. Release reset. Required: writes of 0 to 8190, 8191, 0, 1 on 4 consecutive cycles; `busy`=1 for those 4 cycles; no `gnt` during them. Then A reads of 8191 and 1 each return 0x0000 with `a_rvalid` one cycle later.
- **Write then read across ports.** `CLR_LEN`=0. B writes 0x1234 to address 50. Required: `b_gnt`=1 that cycle, `mem_load`=1, no `b_rvalid`. Next cycle A reads 50. Required: `a_gnt`=1, then `a_rvalid`=1 with `a_rdata`=0x1234 one cycle later; `b_rvalid` stays 0.
- **Round-robin contention.** A and B both hold reads (A addr 1, B addr 2) for 4 cycles from reset. Required: grants A, B, A, B; `rvalid` alternates A, B, A, B, each one cycle later.
- **B write then immediate read.** B writes 0x00FF to address 3, then reads address 3 in the next cycle. Required: `b_rvalid`=1 with 0x00FF two cycles after the write grant.
- **Reset mid-init.** `CLR_LEN`=6, `CLR_BASE`=100. Assert reset after 2 init writes. Required: init restarts at address 100 and performs 6 further writes (100..105); `busy` re-asserts; no `gnt` until init finishes.
- **Reset with read pending.** A read of address 7 is granted; reset is asserted the next cycle. Required: `a_rvalid` stays 0, and no spurious `rvalid` after reset deasserts.
